// File: rtl/mod_updown_counter.sv
// Prescaled up/down modulo counter with terminal-count pulse; PWM compare gated by MOD_UPDOWN_COUNTER_PWM_EN.
// Latency: outputs registered, one edge after the controlling inputs; en=0 freezes all state.
// Backpressure: none; en acts as a stall that holds count, prescaler and pwm_out.
module mod_updown_counter #(
    parameter int W          = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [W-1:0]          load_val,
    input  logic                  dir,
    input  logic [W-1:0]          mod_max,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [W-1:0]          cmp_val,
    output logic [W-1:0]          count,
    output logic                  tc,
    output logic                  pwm_out
);

    logic [W-1:0]          r_count;
    logic [PRESCALE_W-1:0] r_pre;
    logic                  r_tc;
    logic [W-1:0]          w_nxt_count;
    logic [PRESCALE_W-1:0] w_nxt_pre;
    logic                  w_nxt_tc;
    logic                  w_upd;

    always_comb begin
        w_nxt_count = r_count;
        w_nxt_pre   = r_pre;
        w_nxt_tc    = 1'b0;
        w_upd       = clr | load | en;
        if (clr) begin
            w_nxt_count = '0;
            w_nxt_pre   = '0;
        end else if (load) begin
            w_nxt_count = (load_val > mod_max) ? mod_max : load_val;
            w_nxt_pre   = '0;
        end else if (en) begin
            // >= keeps a lowered prescale from stranding the prescaler above it
            if (r_pre >= prescale) begin
                w_nxt_pre = '0;
                if (dir) begin
                    if (r_count >= mod_max) begin
                        w_nxt_count = '0;
                        w_nxt_tc    = 1'b1;
                    end else begin
                        w_nxt_count = r_count + 1'b1;
                    end
                end else begin
                    if (r_count == '0) begin
                        w_nxt_count = mod_max;
                        w_nxt_tc    = 1'b1;
                    end else if (r_count > mod_max) begin
                        w_nxt_count = mod_max;
                    end else begin
                        w_nxt_count = r_count - 1'b1;
                    end
                end
            end else begin
                w_nxt_pre = r_pre + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_nxt_count;
            r_pre   <= w_nxt_pre;
            r_tc    <= w_nxt_tc;
        end
    end

`ifdef MOD_UPDOWN_COUNTER_PWM_EN
    logic r_pwm;

    // compare against the next count so pwm_out lines up with count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else if (w_upd) begin
            r_pwm <= (w_nxt_count < cmp_val);
        end
    end

    assign pwm_out = r_pwm;
`else
    logic w_unused_cmp;
    assign w_unused_cmp = ^{cmp_val, w_upd};
    assign pwm_out      = 1'b0;
`endif

    assign count = r_count;
    assign tc    = r_tc;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter (W=8): directed literal cases plus randomized run against a behavioural model.
module tb_mod_updown_counter;

    localparam int W  = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, clr, load, dir;
    logic [W-1:0]  load_val, mod_max, cmp_val;
    logic [PW-1:0] prescale;
    logic [W-1:0]  count;
    logic          tc, pwm_out;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    int m_count, m_pre;
    bit m_tc, m_pwm;

    mod_updown_counter #(.W(W), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir), .mod_max(mod_max), .prescale(prescale),
        .cmp_val(cmp_val), .count(count), .tc(tc), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit pwm_enabled();
`ifdef MOD_UPDOWN_COUNTER_PWM_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_count = 0; m_pre = 0; m_tc = 0; m_pwm = 0;
    endtask

    // Behavioural step from the counter rules, on plain integers
    task automatic model_edge();
        int mm;
        mm = int'(mod_max);
        m_tc = 0;
        if (clr) begin
            m_count = 0; m_pre = 0;
        end else if (load) begin
            m_count = (int'(load_val) < mm) ? int'(load_val) : mm;
            m_pre = 0;
        end else if (en) begin
            if (m_pre == int'(prescale)) begin
                m_pre = 0;
                if (dir) begin
                    if (m_count >= mm) begin m_count = 0; m_tc = 1; end
                    else m_count = m_count + 1;
                end else begin
                    if (m_count == 0) begin m_count = mm; m_tc = 1; end
                    else if (m_count > mm) m_count = mm;
                    else m_count = m_count - 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end
        if ((clr || load || en) && pwm_enabled())
            m_pwm = (m_count < int'(cmp_val));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("model_count", int'(count), m_count);
            chk("model_tc", int'(tc), int'(m_tc));
            chk("model_pwm", int'(pwm_out), int'(m_pwm));
        end
    end

    initial begin
        int exp_c[5];
        int exp_t[5];
        int highs;
        exp_c = '{1, 2, 3, 4, 0};
        exp_t = '{0, 0, 0, 0, 1};

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b1;
        load_val = '0; mod_max = 8'd4; cmp_val = 8'd2; prescale = '0;
        model_reset();
        #12;
        chk("reset_count", int'(count), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_pwm", int'(pwm_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // up count 0..4 then wrap with tc
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("up_seq_count", int'(count), exp_c[i]);
            chk("up_seq_tc", int'(tc), exp_t[i]);
        end

        // down count with prescale=2
        clr = 1'b1; tick(); clr = 1'b0;
        dir = 1'b0; prescale = 8'd2;
        tick(); tick();
        chk("down_hold", int'(count), 0);
        tick();
        chk("down_wrap_count", int'(count), 4);
        chk("down_wrap_tc", int'(tc), 1);
        tick(); tick(); tick();
        chk("down_next_count", int'(count), 3);
        chk("down_next_tc", int'(tc), 0);

        // load saturates to mod_max; clr beats load
        load = 1'b1; load_val = 8'd9; mod_max = 8'd5; tick();
        chk("load_sat_count", int'(count), 5);
        chk("load_sat_tc", int'(tc), 0);
        clr = 1'b1; tick(); clr = 1'b0; load = 1'b0;
        chk("clr_over_load", int'(count), 0);

        // full-range wrap and en=0 hold
        prescale = '0; dir = 1'b1; mod_max = 8'd255;
        load = 1'b1; load_val = 8'd254; tick(); load = 1'b0;
        tick();
        chk("full_255", int'(count), 255);
        tick();
        chk("full_wrap_count", int'(count), 0);
        chk("full_wrap_tc", int'(tc), 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en_hold_count", int'(count), 0);
            chk("en_hold_tc", int'(tc), 0);
        end
        en = 1'b1;
        tick();
        chk("en_resume", int'(count), 1);

        // async reset mid-operation discards the pending step
        mod_max = 8'd9; prescale = 8'd1;
        load = 1'b1; load_val = 8'd3; tick(); load = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_tc", int'(tc), 0);
        chk("arst_pwm", int'(pwm_out), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_wait", int'(count), 0);
        tick();
        chk("post_rst_step", int'(count), 1);

        // pwm duty: 3 of every 10
        prescale = '0; cmp_val = 8'd3;
        clr = 1'b1; tick(); clr = 1'b0;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            highs += int'(pwm_out);
        end
        chk("pwm_duty", highs, pwm_enabled() ? 6 : 0);

        // randomized run; prescale only moves alongside clr/load
        for (int i = 0; i < 3000; i++) begin
            clr      = ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 15) == 0);
            en       = ($urandom_range(0, 9) < 8);
            dir      = 1'($urandom_range(0, 1));
            load_val = 8'($urandom);
            cmp_val  = 8'($urandom);
            if ($urandom_range(0, 31) == 0)
                mod_max = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
            if (clr || load)
                prescale = 8'($urandom_range(0, 3));
            tick();
        end

        chk_on = 1'b0;
        #10;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter W, default 32: count, load, modulus and compare width in bits.
REQ-002 Parameter PRESCALE_W, default 8: prescaler divisor width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; low freezes the prescaler and the count.
REQ-006 clr  input  1  synchronous clear.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  W  value applied on load.
REQ-009 dir  input  1  1 = count up, 0 = count down.
REQ-010 mod_max  input  W  inclusive top of count range 0..mod_max.
REQ-011 prescale  input  PRESCALE_W  one count step per prescale+1 enabled cycles.
REQ-012 cmp_val  input  W  PWM compare threshold.
REQ-013 count  output  W  registered count value.
REQ-014 tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 pwm_out  output  1  registered compare output.

Function
REQ-016 Priority each cycle SHALL be clr > load > step > hold.
REQ-017 clr SHALL set count=0 and prescaler=0 on the next edge; tc=0.
REQ-018 load SHALL set count=min(load_val, mod_max) and prescaler=0; tc=0.
REQ-019 With en=1 and no clr/load, the prescaler SHALL increment; step SHALL occur when prescaler==prescale, prescaler then returning to 0.
REQ-020 prescale=0 SHALL step every enabled cycle.
REQ-021 Up step: count==mod_max or count>mod_max -> 0 with tc; otherwise count+1.
REQ-022 Down step: count==0 -> mod_max with tc; count>mod_max -> mod_max, no tc; otherwise count-1.
REQ-023 tc SHALL be high exactly in the cycle count shows the wrapped value, low otherwise.
REQ-024 mod_max=0 SHALL hold count=0 and pulse tc on every step.
REQ-025 dir, mod_max, prescale SHALL be sampled every cycle; changes take effect on the next step with no corruption.
REQ-026 en=0 SHALL hold count, prescaler and pwm_out; tc SHALL be 0.
REQ-027 Arithmetic SHALL never overflow past W bits; mod_max=2^W-1 SHALL wrap through 0 as a plain W-bit counter.

Reset
REQ-028 rst_n low SHALL immediately force count=0, prescaler=0, tc=0, pwm_out=0, independent of clk.
REQ-029 Reset mid-operation SHALL discard any pending step; first step after release requires a full prescale+1 enabled cycles.
REQ-030 Deassertion SHALL be taken synchronously to clk by the integrator; no internal synchroniser is present.

Configuration
REQ-031 Macro MOD_UPDOWN_COUNTER_PWM_EN SHALL gate the compare logic.
REQ-032 Defined: pwm_out SHALL register (next count < cmp_val) each edge, so pwm_out tracks count with zero extra lag; cmp_val=0 -> always 0; cmp_val>mod_max -> always 1.
REQ-033 Undefined: pwm_out SHALL be tied 0, cmp_val ignored, no compare logic synthesised; port list unchanged.

Verification
REQ-034 W=8, mod_max=4, prescale=0, dir=1, en=1 -> count 0,1,2,3,4,0; tc high only on the cycle showing 0 after 4.
REQ-035 dir=0, mod_max=4, count=0, prescale=2 -> count 4 after 3 cycles with tc, then 3 after 3 more.
REQ-036 load=1, load_val=9, mod_max=5, clr=0 -> count=5 next cycle, tc=0; clr and load same cycle -> count=0.
REQ-037 Counting up at 3, drop rst_n between edges -> count=0, tc=0, pwm_out=0 immediately; release -> step after prescale+1 cycles.
REQ-038 PWM_EN defined, mod_max=9, cmp_val=3, prescale=0 -> pwm_out high 3 of every 10 cycles; undefined -> pwm_out constant 0.
REQ-039 W=8, mod_max=255, up from 254 -> 255, then 0 with tc; en=0 mid-run holds count for 5 cycles, tc=0.
